// File: rtl/scan_chain_pkg.sv
// Shared scan chain packing and driver-select definitions.
// Used by both the scan controller and the responder.
package scan_chain_pkg;

  localparam int SC_NUM_DESIGNS = 8;
  localparam int SC_NUM_IOS     = 8;
  localparam int SC_W           = SC_NUM_DESIGNS * SC_NUM_IOS;

  typedef enum logic [1:0] {
    DRV_EXT = 2'b00,
    DRV_INT = 2'b01,
    DRV_LA  = 2'b10
  } driver_sel_e;

  // LSB offset of slot d within a packed per-slot bus
  function automatic int slot_off(input int d, input int nios);
    return d * nios;
  endfunction

endpackage

// File: rtl/scan_sig_sync.sv
// Optional flop synchroniser for one scan input,
// with a registered rising-edge detect.
module scan_sig_sync #(
  parameter int SYNC_STAGES = 0,
  parameter bit EDGE        = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise
);

  generate
    if (SYNC_STAGES == 0) begin : g_raw
      assign q = d;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] ff;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ff <= '0;
        end else begin
          ff[0] <= d;
          for (int i = 1; i < SYNC_STAGES; i++)
            ff[i] <= ff[i-1];
        end
      end
      assign q = ff[SYNC_STAGES-1];
    end

    if (EDGE) begin : g_edge
      logic q_d;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q_d <= 1'b0;
        else          q_d <= q;
      end
      assign rise = q & ~q_d;
    end else begin : g_noedge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/scan_chain_responder.sv
// Clocked far-end model of the tiny-design scan chain:
// shift, capture, latch, frame count and short-load error.
module scan_chain_responder
  import scan_chain_pkg::*;
#(
  parameter int NUM_DESIGNS = SC_NUM_DESIGNS,
  parameter int NUM_IOS     = SC_NUM_IOS,
  parameter int SYNC_STAGES = 0,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           scan_clk,
  input  logic                           scan_data_in,
  input  logic                           scan_select,
  input  logic                           scan_latch_en,
  output logic                           scan_data_out,
  output logic [NUM_DESIGNS*NUM_IOS-1:0] design_inputs,
  input  logic [NUM_DESIGNS*NUM_IOS-1:0] design_outputs,
  output logic                           latch_strobe,
  output logic [FRAME_CNT_W-1:0]         frame_count,
  output logic                           load_err,
  input  logic                           clear_err
);

  localparam int W  = NUM_DESIGNS * NUM_IOS;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(W);

  logic s_data, s_sel, rise, lrise;
  logic unused_clk_q, unused_latch_q;
  logic unused_data_rise, unused_sel_rise;

  logic [W-1:0]  chain;
  logic [CW-1:0] bit_cnt;

  scan_sig_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b1)) u_clk (
    .clk(clk), .reset_n(reset_n), .d(scan_clk),
    .q(unused_clk_q), .rise(rise)
  );

  scan_sig_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b0)) u_data (
    .clk(clk), .reset_n(reset_n), .d(scan_data_in),
    .q(s_data), .rise(unused_data_rise)
  );

  scan_sig_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sel (
    .clk(clk), .reset_n(reset_n), .d(scan_select),
    .q(s_sel), .rise(unused_sel_rise)
  );

  scan_sig_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b1)) u_latch (
    .clk(clk), .reset_n(reset_n), .d(scan_latch_en),
    .q(unused_latch_q), .rise(lrise)
  );

  assign scan_data_out = chain[W-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain         <= '0;
      design_inputs <= '0;
      bit_cnt       <= '0;
      frame_count   <= '0;
      load_err      <= 1'b0;
      latch_strobe  <= 1'b0;
    end else begin
      latch_strobe <= lrise;
      if (lrise) begin
        design_inputs <= chain;
        frame_count   <= frame_count + FRAME_CNT_W'(1);
        bit_cnt       <= '0;
      end
      // A same-cycle scan edge overrides the latch's counter clear
      if (rise) begin
        if (s_sel) begin
          chain   <= design_outputs;
          bit_cnt <= '0;
        end else begin
          chain   <= {chain[W-2:0], s_data};
          bit_cnt <= (bit_cnt == CNT_MAX) ? CNT_MAX
                                          : bit_cnt + CW'(1);
        end
      end
      if (lrise && (bit_cnt < CNT_MAX))
        load_err <= 1'b1;
      else if (clear_err)
        load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_chain_responder.sv
// Directed bench for scan_chain_responder, same-domain
// and two-stage synchronised instances side by side.
module tb_scan_chain_responder;
  import scan_chain_pkg::*;

  localparam int W = SC_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic scan_clk = 1'b0;
  logic scan_data_in = 1'b0;
  logic scan_select = 1'b0;
  logic scan_latch_en = 1'b0;
  logic clear_err = 1'b0;
  logic [W-1:0] design_outputs = '0;

  logic sdo0, sdo2, ls0, ls2, err0, err2;
  logic [W-1:0] di0, di2;
  logic [15:0] fc0, fc2;

  int checks = 0;
  int failures = 0;
  int strobes0 = 0;
  int strobes2 = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (ls0) strobes0++;
    if (ls2) strobes2++;
  end

  scan_chain_responder #(.SYNC_STAGES(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .scan_clk(scan_clk), .scan_data_in(scan_data_in),
    .scan_select(scan_select), .scan_latch_en(scan_latch_en),
    .scan_data_out(sdo0), .design_inputs(di0),
    .design_outputs(design_outputs), .latch_strobe(ls0),
    .frame_count(fc0), .load_err(err0), .clear_err(clear_err)
  );

  scan_chain_responder #(.SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .scan_clk(scan_clk), .scan_data_in(scan_data_in),
    .scan_select(scan_select), .scan_latch_en(scan_latch_en),
    .scan_data_out(sdo2), .design_inputs(di2),
    .design_outputs(design_outputs), .latch_strobe(ls2),
    .frame_count(fc2), .load_err(err2), .clear_err(clear_err)
  );

  typedef struct {
    string        name;
    logic         cap_rb;
    logic [W-1:0] dout;
    logic [W-1:0] frame;
    logic [15:0]  exp_fc;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sbit(input logic sel, input logic d, input int half,
                      output logic o);
    scan_select  = sel;
    scan_data_in = d;
    scan_clk     = 1'b1;
    idle(half);
    scan_clk     = 1'b0;
    idle(half);
    o = sdo0;
  endtask

  task automatic latch(input int half);
    scan_latch_en = 1'b1;
    idle(half);
    scan_latch_en = 1'b0;
    idle(half);
  endtask

  task automatic load(input logic [W-1:0] f, input int n, input int half);
    logic o;
    for (int i = 0; i < n; i++) sbit(1'b0, f[W-1-i], half, o);
  endtask

  task automatic readback(input int half, output logic [W-1:0] rb);
    logic o;
    sbit(1'b1, 1'b0, half, o);
    rb[W-1] = o;
    for (int i = 1; i < W; i++) begin
      sbit(1'b0, 1'b0, half, o);
      rb[W-1-i] = o;
    end
  endtask

  initial begin
    logic [W-1:0] rb;
    logic [W-1:0] fa5;
    logic o;
    int s0;

    vecs[0] = '{"load_a5", 1'b0, 64'h0,
                64'h0000_0000_A500_0000, 16'd1};
    vecs[1] = '{"rb_81_3c", 1'b1, 64'h8100_0000_0000_003C,
                64'h0123_4567_89AB_CDEF, 16'd2};
    vecs[2] = '{"b2b_1", 1'b1, 64'hDEAD_BEEF_0F1E_2D3C,
                64'hFFFF_0000_5555_AAAA, 16'd3};
    vecs[3] = '{"b2b_2", 1'b1, 64'h0000_0001_8000_0000,
                64'h8000_0000_0000_0001, 16'd4};
    vecs[4] = '{"b2b_3", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h0, 16'd5};

    idle(2);
    reset_n = 1'b1;
    idle(2);
    chk("rst_di", di0, '0);
    chk("rst_fc", W'(fc0), '0);
    chk("rst_err", W'(err0), '0);
    chk("rst_sdo", W'(sdo0), '0);
    chk("rst_strobe", W'(ls0), '0);

    foreach (vecs[k]) begin
      design_outputs = vecs[k].dout;
      if (vecs[k].cap_rb) begin
        readback(1, rb);
        chk({vecs[k].name, "_rb"}, rb, vecs[k].dout);
      end
      load(vecs[k].frame, W, 1);
      s0 = strobes0;
      latch(1);
      idle(1);
      chk({vecs[k].name, "_di"}, di0, vecs[k].frame);
      chk({vecs[k].name, "_fc"}, W'(fc0), W'(vecs[k].exp_fc));
      chk({vecs[k].name, "_err"}, W'(err0), '0);
      chk({vecs[k].name, "_strobe"}, W'(strobes0 - s0), W'(1));
    end

    design_outputs = '0;
    sbit(1'b1, 1'b0, 1, o);
    load(64'hFFC0_0000_0000_0000, 10, 1);
    latch(1);
    chk("short_err", W'(err0), W'(1));
    chk("short_di", di0, 64'h0000_0000_0000_03FF);
    clear_err = 1'b1;
    idle(1);
    clear_err = 1'b0;
    idle(1);
    chk("clear_err", W'(err0), '0);

    sbit(1'b1, 1'b0, 1, o);
    load(64'hFFC0_0000_0000_0000, 10, 1);
    clear_err     = 1'b1;
    scan_latch_en = 1'b1;
    idle(1);
    clear_err     = 1'b0;
    scan_latch_en = 1'b0;
    idle(1);
    chk("set_over_clear", W'(err0), W'(1));

    s0 = strobes0;
    scan_latch_en = 1'b1;
    idle(6);
    scan_latch_en = 1'b0;
    idle(2);
    chk("held_latch_strobe", W'(strobes0 - s0), W'(1));
    chk("held_latch_fc", W'(fc0), W'(8));

    load(64'h8000_0000_0000_0001, W, 1);
    scan_data_in  = 1'b1;
    scan_select   = 1'b0;
    scan_clk      = 1'b1;
    scan_latch_en = 1'b1;
    idle(1);
    scan_clk      = 1'b0;
    scan_latch_en = 1'b0;
    idle(1);
    chk("preshift_di", di0, 64'h8000_0000_0000_0001);
    latch(1);
    chk("postshift_di", di0, 64'h0000_0000_0000_0003);
    chk("preshift_fc", W'(fc0), W'(10));

    design_outputs = 64'h8000_0000_0000_0000;
    sbit(1'b1, 1'b0, 1, o);
    chk("pre_rst_sdo", W'(sdo0), W'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_sdo", W'(sdo0), '0);
    chk("async_di", di0, '0);
    chk("async_fc", W'(fc0), '0);
    chk("async_err", W'(err0), '0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(4);

    fa5 = W'(8'hA5) << slot_off(3, SC_NUM_IOS);
    load(fa5, W, 4);
    s0 = strobes2;
    scan_latch_en = 1'b1;
    idle(2);
    chk("sync_di_early", di2, '0);
    idle(1);
    chk("sync_di_lat3", di2, 64'h0000_0000_A500_0000);
    idle(5);
    scan_latch_en = 1'b0;
    idle(8);
    chk("sync_fc", W'(fc2), W'(1));
    chk("sync_err", W'(err2), '0);
    chk("sync_strobe", W'(strobes2 - s0), W'(1));
    chk("slow_di0", di0, 64'h0000_0000_A500_0000);
    chk("slow_fc0", W'(fc0), W'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_chain_responder.md
Name: scan_chain_responder

Overview:
- Synchronous far-end model of the tiny-design scan chain; responds to the `scan_controller` protocol (`scan_clk`, `scan_data`, `scan_select`, `scan_latch_en`).
- Replaces NUM_DESIGNS hard scan cells with one clocked block. Used for FPGA prototyping and as the chain model in controller benches.
- Shifts input frames in, latches them to per-slot design inputs, parallel-captures per-slot design outputs, and shifts them back out.
- Also provides frame counting and a sticky short-load error flag.

Parameters:
- NUM_DESIGNS, 8, number of design slots on the chain
- NUM_IOS, 8, bits per slot
- SYNC_STAGES, 0, 0 = scan signals come from the same clock domain as `clk`; 2 or 3 = flop synchroniser per scan input, for use with an external/LA driver
- FRAME_CNT_W, 16, width of frame_count

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- scan_clk  in  1  chain clock, sampled as data
- scan_data_in  in  1  chain serial input, from the controller's scan_data_out
- scan_select  in  1  high at a scan_clk rise = parallel capture
- scan_latch_en  in  1  rising level = transfer chain to design_inputs
- scan_data_out  out  1  chain serial output, to the controller's scan_data_in
- design_inputs  out  NUM_DESIGNS*NUM_IOS  latched inputs; slot d = bits [d*NUM_IOS+NUM_IOS-1 : d*NUM_IOS]
- design_outputs  in  NUM_DESIGNS*NUM_IOS  per-slot outputs, same slot packing
- latch_strobe  out  1  one-cycle pulse when design_inputs updates
- frame_count  out  FRAME_CNT_W  number of latch events, wraps at max
- load_err  out  1  sticky: a latch occurred with fewer than W shifts since the last capture/latch
- clear_err  in  1  synchronous clear of load_err

Behaviour:
- W = NUM_DESIGNS*NUM_IOS. chain[W-1:0] is a register; bit 0 is the input end.
- Input conditioning:
  - SYNC_STAGES=0: s_clk/s_data/s_sel/s_latch are the raw inputs.
  - Otherwise: each input passes through a SYNC_STAGES flop chain, reset to 0.
  - Then sclk_q <= s_clk and latch_q <= s_latch.
  - rise = s_clk & ~sclk_q; lrise = s_latch & ~latch_q.
- Same-domain mode must accept scan_clk toggling every clk cycle (rise every 2 cycles).
- On rise with s_sel=1 (capture):
  - chain <= design_outputs; bit_cnt <= 0.
  - The select/shift decision uses s_sel sampled in the same cycle as rise.
- On rise with s_sel=0 (shift):
  - chain <= {chain[W-2:0], s_data}.
  - bit_cnt <= bit_cnt+1, saturating at W. Width is clog2(W+1).
- scan_data_out = chain[W-1], driven directly from the register.
  - After a capture it presents slot NUM_DESIGNS-1 bit NUM_IOS-1.
  - Each subsequent shift advances to the next lower bit, then the next lower slot.
- Load ordering: the first bit shifted of a W-bit frame ends at chain[W-1].
  - Controller design index k feeds slot NUM_DESIGNS-1-k, MSB first.
  - After a full load, slot d holds the inputs for active_select=d with bit order preserved.
- On lrise:
  - design_inputs <= chain, using the pre-shift chain value if rise occurs in the same cycle; the shift still happens.
  - latch_strobe=1 for exactly that cycle.
  - frame_count++ (wraps).
  - If bit_cnt < W, load_err <= 1.
  - bit_cnt <= 0, unless a shift or capture in the same cycle wins: the rise update takes priority.
- Steady controller frame = capture + (W-1) read shifts + W load shifts + latch. This produces no error.
- load_err: set has priority over clear_err in the same cycle.
- scan_latch_en held high: exactly one latch per rising level.
- Reset (async, any time, including mid-frame) clears all of the following; the first post-reset rise is a fresh edge:
  - chain, design_inputs, sync/edge flops, bit_cnt, frame_count, load_err, latch_strobe
  - scan_data_out therefore = 0
- Latency: SYNC_STAGES+1 clk from a scan input change to the chain/design_inputs update.
  - With SYNC_STAGES>0, the external driver must hold scan_clk high and low for ≥ SYNC_STAGES+1 cycles each.

Decomposition:
- Shared package `scan_chain_pkg`:
  - NUM_DESIGNS/NUM_IOS defaults and the derived width W
  - driver_sel encodings (00 ext, 01 int, 10 LA)
  - slot index/offset helper function, so the controller and the responder agree on packing
- Sub-module `scan_sig_sync`: parameterised SYNC_STAGES synchroniser plus registered rising-edge detect. Instantiated once per scan input (clk, latch with edge; data, select without).

Test Plan:
1. Reset: hold reset_n=0 mid-stimulus -> all outputs 0 immediately (asynchronous); after release, design_inputs=0, frame_count=0.
2. Full load: shift 64 bits with slot 3 = 0xA5, all other slots 0 (slot 7 first, MSB first), then latch -> design_inputs[31:24]=8'hA5, rest 0; latch_strobe high 1 cycle; frame_count=1; load_err=0.
3. Capture/readback: design_outputs slot7=8'h81, slot0=8'h3C; select high at rise, then 63 shifts -> serial sequence starts 1,0,0,0,0,0,0,1 and ends 0,0,1,1,1,1,0,0.
4. Short load: capture, 10 shifts, then latch -> load_err=1 and design_inputs still updated; pulse clear_err -> 0; clear_err in the same cycle as a new short latch -> load_err stays 1.
5. Back-to-back frames: drive three scan_controller-timed frames (scan_clk toggling every cycle) -> frame_count=3, load_err=0, readback matches design_outputs each frame.
6. SYNC_STAGES=2: scan_clk period 8 clk, repeat test 2 -> identical result; design_inputs update 3 cycles after the latch_en rise.
